db9md_pad_scanner: RTL and testbench



---
 rtl/db9md_pkg.sv | 37 +++
 rtl/db9md_pad_decode.sv | 72 +++++++
 rtl/db9md_pad_scanner.sv | 209 ++++++++++++++++++++
 tb/tb_db9md_pad_scanner.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/db9md_pkg.sv
// Shared constants and types for the DB9 Mega Drive pad scanner.
// Bit positions follow the emu joystick word; pin positions follow joy_in.
package db9md_pkg;

    localparam int JB_R     = 32'd0;
    localparam int JB_L     = 32'd1;
    localparam int JB_D     = 32'd2;
    localparam int JB_U     = 32'd3;
    localparam int JB_B     = 32'd4;
    localparam int JB_C     = 32'd5;
    localparam int JB_A     = 32'd6;
    localparam int JB_START = 32'd7;
    localparam int JB_MODE  = 32'd8;
    localparam int JB_X     = 32'd9;
    localparam int JB_Y     = 32'd10;
    localparam int JB_Z     = 32'd11;

    localparam int PIN_UP    = 32'd0;
    localparam int PIN_DOWN  = 32'd1;
    localparam int PIN_LEFT  = 32'd2;
    localparam int PIN_RIGHT = 32'd3;
    localparam int PIN_6     = 32'd4;
    localparam int PIN_9     = 32'd5;

    localparam int NUM_PHASES = 32'd8;
    localparam int PHASE_W    = $clog2(NUM_PHASES);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/db9md_pad_decode.sv
// Per-pad shadow decoder: captures the fields each protocol phase exposes
// and presents the assembled word, masked to zero while no pad is detected.
module db9md_pad_decode
    import db9md_pkg::*;
(
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               clear,
    input  logic               sample,
    input  logic [PHASE_W-1:0] phase,
    input  logic [5:0]         pins,
    output logic [15:0]        word,
    output logic               present,
    output logic               six_btn
);

    logic [11:0] btn_r;
    logic        present_r;
    logic        six_r;
    logic [5:0]  pressed_s;

    assign pressed_s = ~pins;

    // Shadow capture, one field group per protocol phase
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            btn_r     <= 12'h000;
            present_r <= 1'b0;
            six_r     <= 1'b0;
        end else if (clear) begin
            btn_r     <= 12'h000;
            present_r <= 1'b0;
            six_r     <= 1'b0;
        end else if (sample) begin
            case (phase)
                3'd0: begin
                    btn_r[JB_U] <= pressed_s[PIN_UP];
                    btn_r[JB_D] <= pressed_s[PIN_DOWN];
                    btn_r[JB_L] <= pressed_s[PIN_LEFT];
                    btn_r[JB_R] <= pressed_s[PIN_RIGHT];
                    btn_r[JB_B] <= pressed_s[PIN_6];
                    btn_r[JB_C] <= pressed_s[PIN_9];
                end
                3'd1: begin
                    // A pad grounds left and right while select is low
                    present_r       <= pressed_s[PIN_LEFT] & pressed_s[PIN_RIGHT];
                    btn_r[JB_A]     <= pressed_s[PIN_6];
                    btn_r[JB_START] <= pressed_s[PIN_9];
                end
                3'd5: begin
                    six_r <= &pressed_s[3:0];
                end
                3'd6: begin
                    if (six_r) begin
                        btn_r[JB_Z]    <= pressed_s[PIN_UP];
                        btn_r[JB_Y]    <= pressed_s[PIN_DOWN];
                        btn_r[JB_X]    <= pressed_s[PIN_LEFT];
                        btn_r[JB_MODE] <= pressed_s[PIN_RIGHT];
                    end
                end
                default: begin
                    btn_r <= btn_r;
                end
            endcase
        end
    end

    assign word    = present_r ? {4'b0000, btn_r} : 16'h0000;
    assign present = present_r;
    assign six_btn = present_r & six_r;

endmodule

// File: rtl/db9md_pad_scanner.sv
// Time-shares one DB9 input bus between two Mega Drive pads: drives the
// select/mux lines through the 8-phase protocol and commits decoded words.
module db9md_pad_scanner
    import db9md_pkg::*;
#(
    parameter int STEP_CYCLES = 32'd500,
    parameter int IDLE_CYCLES = 32'd100000
)
(
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        enable,
    input  logic [5:0]  joy_in,
    output logic        joy_mdsel,
    output logic        joy_split,
    output logic [15:0] joystick1,
    output logic [15:0] joystick2,
    output logic [1:0]  present,
    output logic [1:0]  six_btn,
    output logic        scan_done
);

    localparam int                 CNT_W      = $clog2(max_int(STEP_CYCLES, IDLE_CYCLES));
    localparam logic [CNT_W-1:0]   CNT_ZERO   = CNT_W'(32'd0);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0]   STEP_LAST  = CNT_W'(STEP_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0]   IDLE_LAST  = CNT_W'(IDLE_CYCLES - 32'd1);
    localparam logic [PHASE_W-1:0] PHASE_ZERO = PHASE_W'(32'd0);
    localparam logic [PHASE_W-1:0] PHASE_ONE  = PHASE_W'(32'd1);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(NUM_PHASES - 32'd1);

    logic [5:0]         sync1_r;
    logic [5:0]         sync2_r;

    state_t             state_r;
    state_t             state_nx_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nx_s;
    logic [PHASE_W-1:0] phase_r;
    logic [PHASE_W-1:0] phase_nx_s;
    logic               sub_r;
    logic               sub_nx_s;
    logic               scan_start_s;
    logic               last_sample_s;
    logic               sample_s;

    logic               mdsel_r;
    logic               split_r;
    logic [15:0]        joy1_r;
    logic [15:0]        joy2_r;
    logic [1:0]         present_r;
    logic [1:0]         six_r;
    logic               done_r;
    logic               commit_r;

    logic [15:0]        word1_s;
    logic [15:0]        word2_s;
    logic               pres1_s;
    logic               pres2_s;
    logic               six1_s;
    logic               six2_s;

    // Two-flop synchronizer for the asynchronous pad pins (idle level high)
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync1_r <= 6'h3F;
            sync2_r <= 6'h3F;
        end else begin
            sync1_r <= joy_in;
            sync2_r <= sync1_r;
        end
    end

    // Scan sequencer state register
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            phase_r <= PHASE_ZERO;
            sub_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            phase_r <= phase_nx_s;
            sub_r   <= sub_nx_s;
        end
    end

    // Scan sequencer next state: idle timer, then 8 phases x 2 pad windows
    always_comb begin
        state_nx_s    = state_r;
        cnt_nx_s      = cnt_r;
        phase_nx_s    = phase_r;
        sub_nx_s      = sub_r;
        scan_start_s  = 1'b0;
        last_sample_s = 1'b0;
        if (!enable) begin
            state_nx_s = IDLE;
            cnt_nx_s   = CNT_ZERO;
            phase_nx_s = PHASE_ZERO;
            sub_nx_s   = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cnt_r == IDLE_LAST) begin
                        state_nx_s   = SCAN;
                        cnt_nx_s     = CNT_ZERO;
                        phase_nx_s   = PHASE_ZERO;
                        sub_nx_s     = 1'b0;
                        scan_start_s = 1'b1;
                    end else begin
                        cnt_nx_s = cnt_r + CNT_ONE;
                    end
                end
                SCAN: begin
                    if (cnt_r != STEP_LAST) begin
                        cnt_nx_s = cnt_r + CNT_ONE;
                    end else if (!sub_r) begin
                        cnt_nx_s = CNT_ZERO;
                        sub_nx_s = 1'b1;
                    end else if (phase_r != PHASE_LAST) begin
                        cnt_nx_s   = CNT_ZERO;
                        sub_nx_s   = 1'b0;
                        phase_nx_s = phase_r + PHASE_ONE;
                    end else begin
                        state_nx_s    = IDLE;
                        cnt_nx_s      = CNT_ZERO;
                        sub_nx_s      = 1'b0;
                        phase_nx_s    = PHASE_ZERO;
                        last_sample_s = 1'b1;
                    end
                end
                default: begin
                    state_nx_s = IDLE;
                    cnt_nx_s   = CNT_ZERO;
                    phase_nx_s = PHASE_ZERO;
                    sub_nx_s   = 1'b0;
                end
            endcase
        end
    end

    // The synchronized bus is stable by the last cycle of each window
    assign sample_s = (state_r == SCAN) && (cnt_r == STEP_LAST) && enable;

    db9md_pad_decode u_pad1 (
        .clk_sys (clk_sys),
        .reset   (reset),
        .clear   (scan_start_s),
        .sample  (sample_s & ~sub_r),
        .phase   (phase_r),
        .pins    (sync2_r),
        .word    (word1_s),
        .present (pres1_s),
        .six_btn (six1_s)
    );

    db9md_pad_decode u_pad2 (
        .clk_sys (clk_sys),
        .reset   (reset),
        .clear   (scan_start_s),
        .sample  (sample_s & sub_r),
        .phase   (phase_r),
        .pins    (sync2_r),
        .word    (word2_s),
        .present (pres2_s),
        .six_btn (six2_s)
    );

    // Registered pad lines and atomic commit of the decoded shadows
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            mdsel_r   <= 1'b1;
            split_r   <= 1'b0;
            joy1_r    <= 16'h0000;
            joy2_r    <= 16'h0000;
            present_r <= 2'b00;
            six_r     <= 2'b00;
            done_r    <= 1'b0;
            commit_r  <= 1'b0;
        end else begin
            mdsel_r  <= (state_nx_s == SCAN) ? ~phase_nx_s[0] : 1'b1;
            split_r  <= (state_nx_s == SCAN) ? sub_nx_s : 1'b0;
            commit_r <= last_sample_s;
            done_r   <= commit_r & enable;
            if (!enable) begin
                // Dropping out of SNAC mode must not leave buttons held
                joy1_r    <= 16'h0000;
                joy2_r    <= 16'h0000;
                present_r <= 2'b00;
                six_r     <= 2'b00;
            end else if (commit_r) begin
                joy1_r    <= word1_s;
                joy2_r    <= word2_s;
                present_r <= {pres2_s, pres1_s};
                six_r     <= {six2_s, six1_s};
            end
        end
    end

    assign joy_mdsel = mdsel_r;
    assign joy_split = split_r;
    assign joystick1 = joy1_r;
    assign joystick2 = joy2_r;
    assign present   = present_r;
    assign six_btn   = six_r;
    assign scan_done = done_r;

endmodule

// File: tb/tb_db9md_pad_scanner.sv
// Directed bench for db9md_pad_scanner with a behavioural 3/6-button pad
// model on each port; STEP_CYCLES=4 and IDLE_CYCLES=64.
module tb_db9md_pad_scanner;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        enable;
    logic [5:0]  joy_in;
    logic        joy_mdsel;
    logic        joy_split;
    logic [15:0] joystick1;
    logic [15:0] joystick2;
    logic [1:0]  present;
    logic [1:0]  six_btn;
    logic        scan_done;

    int checks = 0;
    int failures = 0;

    // Pad kinds: 0 absent, 1 three-button, 2 six-button. Buttons use the joystick bit map.
    logic [1:0]  p1_kind;
    logic [1:0]  p2_kind;
    logic [11:0] p1_btn;
    logic [11:0] p2_btn;
    int          lows = 0;
    int          hi_cnt = 0;
    logic        sel_prev = 1'b1;

    db9md_pad_scanner #(.STEP_CYCLES(4), .IDLE_CYCLES(64)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .enable    (enable),
        .joy_in    (joy_in),
        .joy_mdsel (joy_mdsel),
        .joy_split (joy_split),
        .joystick1 (joystick1),
        .joystick2 (joystick2),
        .present   (present),
        .six_btn   (six_btn),
        .scan_done (scan_done)
    );

    always #5 clk_sys = ~clk_sys;

    // Returns active-low pins {pin9, pin6, right, left, down, up}
    function automatic logic [5:0] pad_pins(input logic [1:0] kind, input logic [11:0] b,
                                            input logic sel, input int nlow);
        logic [5:0] p;
        if (kind == 2'd0) begin
            p = 6'b111111;
        end else if (sel) begin
            if (kind == 2'd2 && nlow == 3) p = {~b[5], ~b[4], ~b[8], ~b[9], ~b[10], ~b[11]};
            else                           p = {~b[5], ~b[4], ~b[0], ~b[1], ~b[2], ~b[3]};
        end else begin
            if (kind == 2'd2 && nlow == 3) p = {~b[7], ~b[6], 4'b0000};
            else                           p = {~b[7], ~b[6], 1'b0, 1'b0, ~b[2], ~b[3]};
        end
        return p;
    endfunction

    // Pad-side select edge counter with a long-high timeout
    always @(negedge clk_sys) begin
        if (sel_prev && !joy_mdsel) lows <= lows + 1;
        else if (hi_cnt >= 12)      lows <= 0;
        hi_cnt   <= joy_mdsel ? hi_cnt + 1 : 0;
        sel_prev <= joy_mdsel;
    end

    assign joy_in = joy_split ? pad_pins(p2_kind, p2_btn, joy_mdsel, lows)
                              : pad_pins(p1_kind, p1_btn, joy_mdsel, lows);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [15:0] j1, input logic [15:0] j2,
                           input logic [1:0] pr, input logic [1:0] sx);
        chk({tag, "_joystick1"}, 32'(joystick1), 32'(j1));
        chk({tag, "_joystick2"}, 32'(joystick2), 32'(j2));
        chk({tag, "_present"},   32'(present),   32'(pr));
        chk({tag, "_six_btn"},   32'(six_btn),   32'(sx));
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        do begin
            @(posedge clk_sys); #1;
            n++;
        end while (!scan_done && n < 400);
        chk({tag, "_scan_done_seen"}, 32'(scan_done), 32'd1);
    endtask

    initial begin
        int   n;
        logic ok;

        reset   = 1'b1;
        enable  = 1'b1;
        p1_kind = 2'd1; p1_btn = 12'h048;   // A + Up
        p2_kind = 2'd1; p2_btn = 12'h000;
        repeat (3) @(posedge clk_sys);
        #1;
        chk("rst_mdsel", 32'(joy_mdsel), 32'd1);
        chk("rst_split", 32'(joy_split), 32'd0);
        chk("rst_done",  32'(scan_done), 32'd0);
        chk_out("rst", 16'h0000, 16'h0000, 2'b00, 2'b00);

        // Cycle count starts with the last reset edge as cycle 1.
        reset = 1'b0;
        n = 1;
        repeat (63) @(posedge clk_sys);
        #1;
        n += 63;
        chk("idle_end_mdsel", 32'(joy_mdsel), 32'd1);
        chk("idle_end_split", 32'(joy_split), 32'd0);

        // Scan waveform: mdsel H,L,... per 8 cycles, split toggles every 4.
        for (int k = 0; k < 64; k++) begin
            @(posedge clk_sys); #1;
            n++;
            chk("wave_mdsel", 32'(joy_mdsel), (((k / 8) % 2) == 0) ? 32'd1 : 32'd0);
            chk("wave_split", 32'(joy_split), (((k / 4) % 2) == 1) ? 32'd1 : 32'd0);
            chk("wave_no_done", 32'(scan_done), 32'd0);
            chk("wave_j1_stable", 32'(joystick1), 32'd0);
        end
        while (!scan_done && n < 300) begin
            @(posedge clk_sys); #1;
            n++;
        end
        chk("first_done_cycle", 32'(n), 32'd130);
        chk_out("three_btn", 16'h0048, 16'h0000, 2'b11, 2'b00);
        @(posedge clk_sys); #1;
        chk("done_one_cycle", 32'(scan_done), 32'd0);
        chk("post_mdsel", 32'(joy_mdsel), 32'd1);

        // Six-button pad 1 with Mode+X, pad 2 unplugged
        p1_kind = 2'd2; p1_btn = 12'h300;
        p2_kind = 2'd0; p2_btn = 12'h000;
        wait_done("six");
        chk_out("six", 16'h0300, 16'h0000, 2'b01, 2'b01);

        // Pad 1 B, pad 2 Start
        p1_kind = 2'd1; p1_btn = 12'h010;
        p2_kind = 2'd1; p2_btn = 12'h080;
        wait_done("bs");
        chk_out("bs", 16'h0010, 16'h0080, 2'b11, 2'b00);

        // Next scan begins 64 edges after scan_done; 88 edges lands in phase 3.
        repeat (88) @(posedge clk_sys);
        #1;
        p1_btn = 12'h028;   // C + Up, too late for phases 0/1
        ok = 1'b1;
        n = 0;
        do begin
            @(posedge clk_sys); #1;
            n++;
            if (!scan_done && joystick1 !== 16'h0010) ok = 1'b0;
        end while (!scan_done && n < 400);
        chk("mid_change_stable", 32'(ok), 32'd1);
        chk("mid_change_done", 32'(scan_done), 32'd1);
        chk_out("mid_change", 16'h0010, 16'h0080, 2'b11, 2'b00);
        wait_done("cu");
        chk_out("cu", 16'h0028, 16'h0080, 2'b11, 2'b00);

        // 100 edges after scan_done: phase 4, pad-2 window
        repeat (100) @(posedge clk_sys);
        #1;
        chk("pre_drop_split", 32'(joy_split), 32'd1);
        chk("pre_drop_j1", 32'(joystick1), 32'h0028);
        enable = 1'b0;
        @(posedge clk_sys); #1;
        chk("drop_mdsel", 32'(joy_mdsel), 32'd1);
        chk("drop_split", 32'(joy_split), 32'd0);
        chk("drop_done",  32'(scan_done), 32'd0);
        chk_out("drop", 16'h0000, 16'h0000, 2'b00, 2'b00);
        ok = 1'b1;
        repeat (20) begin
            @(posedge clk_sys); #1;
            if (scan_done || !joy_mdsel || joy_split || joystick1 != 16'h0000) ok = 1'b0;
        end
        chk("disabled_quiet", 32'(ok), 32'd1);

        // Re-enable: 64 idle + 64 scan + 1 commit edges
        enable = 1'b1;
        n = 0;
        do begin
            @(posedge clk_sys); #1;
            n++;
        end while (!scan_done && n < 300);
        chk("reenable_done_cycle", 32'(n), 32'd129);
        chk_out("reenable", 16'h0028, 16'h0080, 2'b11, 2'b00);

        // Reset in phase 2 with nonzero outputs
        repeat (80) @(posedge clk_sys);
        #1;
        chk("pre_reset_j1", 32'(joystick1), 32'h0028);
        reset = 1'b1;
        @(posedge clk_sys); #1;
        chk("mid_rst_mdsel", 32'(joy_mdsel), 32'd1);
        chk("mid_rst_split", 32'(joy_split), 32'd0);
        chk("mid_rst_done",  32'(scan_done), 32'd0);
        chk_out("mid_rst", 16'h0000, 16'h0000, 2'b00, 2'b00);
        reset = 1'b0;
        ok = 1'b1;
        repeat (70) begin
            @(posedge clk_sys); #1;
            if (scan_done || joystick1 != 16'h0000 || present != 2'b00) ok = 1'b0;
        end
        chk("no_partial_commit", 32'(ok), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
